// File: rtl/mult_pkg.sv
// Shared definitions for the iterative shift-add multiplier:
// FSM state encoding and the iteration-counter width helper.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } mult_state_e;

  // Counter wide enough to hold 0..width inclusive.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_neg.sv
// Conditional two's-complement negate. Used for operand magnitude
// extraction and for the final sign fix-up of the product.
module mult_neg
  import mult_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         neg_i,
  input  logic [W-1:0] val_i,
  output logic [W-1:0] val_o
);

  // Negate when requested; the most negative value maps onto itself,
  // which reads correctly as its magnitude when treated as unsigned.
  assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/seq_multiplier.sv
// Iterative WIDTH x WIDTH -> 2*WIDTH shift-add multiplier, one multiplier
// bit per cycle, with per-operation signed/unsigned select.
// Optional build macro: MULT_EARLY_TERM_EN -- leave CALC as soon as the
// remaining multiplier bits are all zero (same result, shorter latency).
//
// Handshake: start is accepted on a clock edge where busy==0 (including
// the cycle in which done is high); operands and is_signed are sampled on
// that edge only. busy is high from the following edge until the done
// edge; done is a single-cycle pulse and product is valid from then on,
// held until the next done or reset. start while busy is ignored.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [1:0]         dbg_state_o
);

  localparam int CNT_W = cnt_w(WIDTH);

  mult_state_e        state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] fixed_acc;
  logic               last_calc;

  mult_neg #(.W(WIDTH)) u_abs_a (
    .neg_i (is_signed & op_a[WIDTH-1]),
    .val_i (op_a),
    .val_o (abs_a)
  );

  mult_neg #(.W(WIDTH)) u_abs_b (
    .neg_i (is_signed & op_b[WIDTH-1]),
    .val_i (op_b),
    .val_o (abs_b)
  );

  mult_neg #(.W(2*WIDTH)) u_fix (
    .neg_i (sign_q),
    .val_i (acc_q),
    .val_o (fixed_acc)
  );

  // Decide whether the current CALC cycle is the final one.
`ifdef MULT_EARLY_TERM_EN
  always_comb begin
    last_calc = (mplier_q[WIDTH-1:1] == '0) || (cnt_q == CNT_W'(WIDTH - 1));
  end
`else
  always_comb begin
    last_calc = (cnt_q == CNT_W'(WIDTH - 1));
  end
`endif

  // Next-state and datapath update for IDLE -> CALC -> FIX -> IDLE.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    product_d = product_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, abs_a};
          mplier_d = abs_b;
          sign_d   = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_calc) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        product_d = fixed_acc;
        done_d    = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign product     = product_q;
  assign dbg_state_o = state_q;

endmodule
